// File: rtl/iob_ahb_ram_ws_pkg.sv
// Shared encodings and the transfer legality rule for the wait-state AHB-lite RAM.
package iob_ahb_ram_ws_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // lg = log2(bytes per word); depth = number of words
    function automatic logic xfer_legal(input logic [63:0] addr, input logic [2:0] size,
                                        input int unsigned lg, input logic [63:0] depth);
        logic [63:0] mask;
        mask = (64'd1 << size) - 64'd1;
        if (32'(size) > lg) return 1'b0;
        if ((addr & mask) != 64'd0) return 1'b0;
        return (addr >> lg) < depth;
    endfunction

endpackage

// File: rtl/iob_ahb_ram_ws_lanes.sv
// Byte-lane strobe decoder: a lane is enabled when it falls in [addr_lo, addr_lo + 2^size).
module iob_ahb_ram_ws_lanes #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                      size,
    input  logic [$clog2(DATA_W/8)-1:0]     addr_lo,
    output logic [DATA_W/8-1:0]             strb
);

    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
        assign strb[gi] = (gi >= int'(addr_lo)) && (gi < int'(addr_lo) + (1 << size));
    end

endmodule

// File: rtl/iob_ahb_ram_ws.sv
// AHB-lite subordinate RAM with programmable wait states, two-cycle ERROR response
// and write-to-read forwarding for back-to-back accesses to the same word.
module iob_ahb_ram_ws
    import iob_ahb_ram_ws_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int NB    = DATA_W / 8;
    localparam int LG    = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WS_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              wr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [2:0]        size_reg;
    logic [LG-1:0]     lo_reg;
    logic              rd_valid_reg;
    logic [IDX_W-1:0]  rd_idx_reg;
    logic              fwd_hit_reg;
    logic              fwd_valid_reg;
    logic [IDX_W-1:0]  fwd_idx_reg;
    logic [NB-1:0]     fwd_strb_reg;
    logic [DATA_W-1:0] fwd_data_reg;

    logic              ready_state, accept, legal, rd_issue, commit;
    logic [IDX_W-1:0]  addr_idx;
    logic [NB-1:0]     strb;
    logic [DATA_W-1:0] ram_q, rd_data;

    assign ready_state = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign accept      = HSEL && HREADY && ready_state
                         && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign legal       = xfer_legal(64'(HADDR), HSIZE, LG, 64'(DEPTH));
    assign addr_idx    = HADDR[LG +: IDX_W];
    assign rd_issue    = accept && legal && !HWRITE;
    assign commit      = (state_reg == ST_DATA) && wr_reg;

    assign HREADYOUT = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
    assign HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    iob_ahb_ram_ws_lanes #(.DATA_W(DATA_W)) u_lanes (
        .size    (size_reg),
        .addr_lo (lo_reg),
        .strb    (strb)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_WAIT: begin
                if (cnt_reg == 3'd0) state_next = ST_DATA;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                if (!accept) begin
                    state_next = ST_IDLE;
                end else if (!legal) begin
                    state_next = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_next = ST_WAIT;
                    cnt_next   = WS_INIT;
                end else begin
                    state_next = ST_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 3'd0;
            wr_reg        <= 1'b0;
            idx_reg       <= '0;
            size_reg      <= 3'd0;
            lo_reg        <= '0;
            rd_valid_reg  <= 1'b0;
            rd_idx_reg    <= '0;
            fwd_hit_reg   <= 1'b0;
            fwd_valid_reg <= 1'b0;
            fwd_idx_reg   <= '0;
            fwd_strb_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wr_reg   <= HWRITE;
                idx_reg  <= addr_idx;
                size_reg <= HSIZE;
                lo_reg   <= HADDR[LG-1:0];
            end
            if (commit) begin
                fwd_valid_reg <= 1'b1;
                fwd_idx_reg   <= idx_reg;
                fwd_strb_reg  <= strb;
                fwd_data_reg  <= HWDATA;
            end
            // The RAM read below sees pre-commit contents, so remember a same-word collision
            if (rd_issue) begin
                rd_valid_reg <= 1'b1;
                rd_idx_reg   <= addr_idx;
                fwd_hit_reg  <= commit && (addr_idx == idx_reg);
            end
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_ram
        logic [7:0] mem [DEPTH];
        logic [7:0] q_reg;
        always_ff @(posedge clk_i) begin
            if (commit && strb[gi]) mem[idx_reg] <= HWDATA[gi*8 +: 8];
            if (rd_issue)           q_reg        <= mem[addr_idx];
        end
        assign ram_q[gi*8 +: 8] = q_reg;
    end

    always_comb begin
        rd_data = ram_q;
        for (int i = 0; i < NB; i++) begin
            if (fwd_hit_reg && fwd_valid_reg && (fwd_idx_reg == rd_idx_reg) && fwd_strb_reg[i])
                rd_data[i*8 +: 8] = fwd_data_reg[i*8 +: 8];
        end
    end

    assign HRDATA = rd_valid_reg ? rd_data : '0;

endmodule

// File: tb/tb_iob_ahb_ram_ws.sv
// Randomized bench for iob_ahb_ram_ws: three configurations (32b/0ws, 32b/3ws, 64b/0ws)
// driven by a pipelined AHB-lite manager and checked against a byte-array memory model.
module tb_iob_ahb_ram_ws;
    import iob_ahb_ram_ws_pkg::*;

    localparam int DEPTH  = 40;
    localparam int ADDR_W = 16;

    typedef struct {
        bit          hsel;
        logic [1:0]  trans;
        bit          wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int DW = (gi == 2) ? 64 : 32;
        localparam int WS = (gi == 1) ? 3 : 0;
        localparam int NB = DW / 8;
        localparam int LG = $clog2(NB);

        logic              arst, hsel, hwrite, hready, hreadyout, hresp, hold_low;
        logic [ADDR_W-1:0] haddr;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [DW-1:0]     hwdata, hrdata;
        logic [7:0]        mem_model [DEPTH*NB];
        xfer_t             sched [$];
        bit                done_flag = 1'b0;

        assign hready = hreadyout & ~hold_low;

        iob_ahb_ram_ws #(
            .DATA_W(DW), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WS)
        ) u_dut (
            .clk_i(clk), .arst_i(arst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
            .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
            .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
        );

        function automatic bit legal_m(input logic [15:0] a, input logic [2:0] s);
            int unsigned bytes;
            bytes = 1 << s;
            return (int'(s) <= LG) && (int'(a) % bytes == 0) && (int'(a) / NB < DEPTH);
        endfunction

        function automatic logic [63:0] model_word(input logic [15:0] a);
            logic [63:0] w;
            int base;
            w = '0;
            base = (int'(a) / NB) * NB;
            for (int b = 0; b < NB; b++) w[b*8 +: 8] = mem_model[base + b];
            return w;
        endfunction

        function automatic void model_write(input logic [15:0] a, input logic [2:0] s,
                                            input logic [63:0] d);
            for (int b = 0; b < (1 << s); b++)
                mem_model[int'(a) + b] = d[((int'(a) + b) % NB) * 8 +: 8];
        endfunction

        function automatic void push(input bit w, input int a, input int s, input logic [63:0] d);
            xfer_t x;
            x.hsel  = 1'b1;
            x.trans = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            x.wr    = w;
            x.addr  = 16'(a);
            x.size  = 3'(s);
            x.wdata = d;
            sched.push_back(x);
        endfunction

        function automatic void push_filler();
            xfer_t x;
            x.hsel  = ($urandom_range(0, 1) == 0);
            x.trans = x.hsel ? (($urandom_range(0, 1) == 0) ? HTRANS_IDLE : HTRANS_BUSY)
                             : 2'($urandom_range(0, 3));
            x.wr    = ($urandom_range(0, 1) == 0);
            x.addr  = 16'($urandom_range(0, 16'hFFFF));
            x.size  = 3'($urandom_range(0, 7));
            x.wdata = {$urandom, $urandom};
            sched.push_back(x);
        endfunction

        task automatic bus_idle();
            hsel   = 1'b0;
            htrans = HTRANS_IDLE;
            hwrite = 1'b0;
            haddr  = '0;
            hsize  = HSIZE_BYTE;
        endtask

        task automatic run_sched();
            xfer_t dp, ap;
            bit    dp_v, ap_v, rdy, lg_ok;
            int    waits;
            dp_v  = 1'b0;
            ap_v  = 1'b0;
            waits = 0;
            while (sched.size() > 0 || ap_v || dp_v) begin
                @(negedge clk);
                rdy = hreadyout;
                if (dp_v) begin
                    lg_ok = legal_m(dp.addr, dp.size);
                    if (rdy) begin
                        check_val($sformatf("c%0d_waits@%h", gi, dp.addr), 64'(waits), 64'(lg_ok ? WS : 1));
                        check_val($sformatf("c%0d_resp@%h", gi, dp.addr), 64'(hresp), 64'(!lg_ok));
                        if (lg_ok && !dp.wr)
                            check_val($sformatf("c%0d_rdata@%h", gi, dp.addr), 64'(hrdata), model_word(dp.addr));
                        if (lg_ok && dp.wr) model_write(dp.addr, dp.size, dp.wdata);
                        $display("c%0d %s @%h size=%0d resp=%0d waits=%0d wdata=%h rdata=%h",
                                 gi, dp.wr ? "WR" : "RD", dp.addr, dp.size, hresp, waits,
                                 dp.wdata[DW-1:0], hrdata);
                    end else begin
                        waits++;
                        check_val($sformatf("c%0d_wait_resp@%h", gi, dp.addr), 64'(hresp), 64'(!lg_ok));
                        if (waits > 20) begin
                            check_val($sformatf("c%0d_timeout@%h", gi, dp.addr), 64'(waits), 64'(lg_ok ? WS : 1));
                            sched.delete();
                            dp_v = 1'b0;
                            ap_v = 1'b0;
                            break;
                        end
                    end
                end else begin
                    check_val($sformatf("c%0d_idle_out", gi), 64'({hreadyout, hresp}), 64'(2'b10));
                end
                hwdata = (dp_v && dp.wr) ? dp.wdata[DW-1:0] : DW'({$urandom, $urandom});
                if (!ap_v && sched.size() > 0) begin
                    ap   = sched.pop_front();
                    ap_v = 1'b1;
                end
                if (ap_v) begin
                    hsel   = ap.hsel;
                    htrans = ap.trans;
                    hwrite = ap.wr;
                    haddr  = ap.addr;
                    hsize  = ap.size;
                end else begin
                    bus_idle();
                end
                if (rdy) begin
                    dp_v = ap_v && ap.hsel && ap.trans[1];
                    if (dp_v) begin
                        dp    = ap;
                        waits = 0;
                    end
                    ap_v = 1'b0;
                end
            end
            bus_idle();
        endtask

        initial begin
            logic [63:0] d;
            arst     = 1'b1;
            hold_low = 1'b0;
            hwdata   = '0;
            bus_idle();
            @(negedge clk);
            check_val($sformatf("c%0d_rst_readyout", gi), 64'(hreadyout), 64'(1));
            check_val($sformatf("c%0d_rst_resp", gi), 64'(hresp), 64'(0));
            check_val($sformatf("c%0d_rst_rdata", gi), 64'(hrdata), 64'(0));
            @(negedge clk);
            arst = 1'b0;

            // Fill every word so later reads compare against defined contents
            for (int i = 0; i < DEPTH; i++) push(1'b1, i * NB, LG, {$urandom, $urandom});
            run_sched();

            // Back-to-back forwarding and sub-word merges
            push(1'b1, 'h10, 2, 64'hDEADBEEF);
            push(1'b0, 'h10, 2, 64'h0);
            push(1'b1, 'h10, 2, 64'h11223344);
            d = {$urandom, $urandom};
            d[31:24] = 8'hAA;
            push(1'b1, 'h13, 0, d);
            push(1'b0, 'h10, 2, 64'h0);
            d = {$urandom, $urandom};
            d[31:16] = 16'h5566;
            push(1'b1, 'h12, 1, d);
            push(1'b0, 'h10, 2, 64'h0);
            // Illegal transfers, then confirm nothing changed
            push(1'b1, 'h01, 1, {$urandom, $urandom});
            push(1'b1, 'h10, 3, {$urandom, $urandom});
            push(1'b1, DEPTH * NB, 2, {$urandom, $urandom});
            push(1'b0, DEPTH * NB, 2, 64'h0);
            push(1'b0, 'h10, 2, 64'h0);
            // Upper-half word and doubleword accesses
            push(1'b1, 'h0C, 2, {$urandom, $urandom});
            push(1'b0, 'h08, 3, 64'h0);
            push(1'b0, 'h08, 2, 64'h0);
            push(1'b1, 'h08, 3, {$urandom, $urandom});
            push(1'b0, 'h08, 3, 64'h0);
            // Highest legal word
            push(1'b1, (DEPTH - 1) * NB, LG, {$urandom, $urandom});
            push(1'b0, (DEPTH - 1) * NB, LG, 64'h0);
            run_sched();

            for (int k = 0; k < 300; k++) begin
                int r, sz, idx, a;
                r = $urandom_range(0, 99);
                if (r < 12) begin
                    push_filler();
                end else begin
                    sz = (r < 20) ? $urandom_range(0, 7) : $urandom_range(0, LG);
                    case ($urandom_range(0, 9))
                        0:       idx = DEPTH;
                        1:       idx = $urandom_range(0, 65535 / NB);
                        2:       idx = DEPTH - 1;
                        default: idx = $urandom_range(0, 5);
                    endcase
                    a = idx * NB + ($urandom_range(0, NB - 1) & ~((1 << sz) - 1));
                    if (r >= 95) a = a + 1;
                    push($urandom_range(0, 1) == 1, a & 16'hFFFF, sz, {$urandom, $urandom});
                end
            end
            run_sched();

            // HREADY held low by another subordinate: the address phase must be ignored
            @(negedge clk);
            hold_low = 1'b1;
            hsel     = 1'b1;
            htrans   = HTRANS_NONSEQ;
            hwrite   = 1'b1;
            haddr    = '0;
            hsize    = 3'(LG);
            hwdata   = DW'({$urandom, $urandom});
            @(negedge clk);
            check_val($sformatf("c%0d_hready_low", gi), 64'({hreadyout, hresp}), 64'(2'b10));
            hold_low = 1'b0;
            bus_idle();
            hwdata = DW'({$urandom, $urandom});
            @(negedge clk);
            hwdata = DW'({$urandom, $urandom});
            push(1'b0, 0, LG, 64'h0);
            run_sched();

            // Reset in the middle of a write data phase discards the write
            @(negedge clk);
            hsel   = 1'b1;
            htrans = HTRANS_NONSEQ;
            hwrite = 1'b1;
            haddr  = 16'h20;
            hsize  = 3'(LG);
            @(negedge clk);
            bus_idle();
            hwdata = DW'({$urandom, $urandom});
            arst   = 1'b1;
            #1;
            check_val($sformatf("c%0d_arst_readyout", gi), 64'(hreadyout), 64'(1));
            check_val($sformatf("c%0d_arst_resp", gi), 64'(hresp), 64'(0));
            check_val($sformatf("c%0d_arst_rdata", gi), 64'(hrdata), 64'(0));
            @(negedge clk);
            arst = 1'b0;
            push(1'b0, 'h20, LG, 64'h0);
            run_sched();

            done_flag = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].done_flag && g_cfg[1].done_flag && g_cfg[2].done_flag) && cyc < 50000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("all_cfg_done", 64'(cyc < 50000), 64'(1));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
